// File: rtl/div_pkg.sv
// Defaults shared by the divider, its result collector and their benches.
package div_pkg;

    localparam int DIV_WIDTH         = 32;
    localparam int DIV_LATENCY       = 32;
    localparam int DIV_COLLECT_DEPTH = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/div_collect_fifo.sv
// Result buffer behind the divider: synchronous write, read from the registered head pointer.
import div_pkg::*;

module div_collect_fifo #(
    parameter int DW    = DIV_WIDTH,
    parameter int DEPTH = DIV_COLLECT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DW-1:0]          wr_data,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DW-1:0]          rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_en;

    assign rd_valid = (count != '0);
    assign rd_en    = rd_valid && rd_ready;

    // An empty buffer presents zero so stale storage never leaks out after reset.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_collect.sv
// Collects fixed-latency divider results in issue order, with credit-based back-pressure.
// Define DIV_COLLECT_ZERO_FLAG_EN to carry the zero-divisor flag with each result onto out_dbz.
import div_pkg::*;

module div_collect #(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int LATENCY = DIV_LATENCY,
    parameter int DEPTH   = DIV_COLLECT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_b_zero,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       div_z,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_dbz,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = max_int(CW, IW) + 1;

    logic               issue;
    logic               exit_tag;
    logic [LATENCY-1:0] tag_sr;
    logic [IW-1:0]      inflight;
    logic [SW-1:0]      credit_used;

    // Every slot is reserved at issue time, so a landing result always finds room.
    assign credit_used = SW'(count) + SW'(inflight);
    assign in_ready    = credit_used < SW'(DEPTH);
    assign issue       = in_valid && in_ready;
    assign exit_tag    = tag_sr[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_sr   <= '0;
            inflight <= '0;
        end else begin
            tag_sr   <= (tag_sr << 1) | LATENCY'(issue);
            inflight <= inflight + IW'(issue) - IW'(exit_tag);
        end
    end

`ifdef DIV_COLLECT_ZERO_FLAG_EN
    logic [LATENCY-1:0] zf_sr;
    logic [WIDTH:0]     fifo_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_sr <= '0;
        end else begin
            zf_sr <= (zf_sr << 1) | LATENCY'(issue && in_b_zero);
        end
    end

    div_collect_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (exit_tag),
        .wr_data  ({zf_sr[LATENCY-1], div_z}),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (fifo_rd),
        .count    (count)
    );

    assign out_data = fifo_rd[WIDTH-1:0];
    assign out_dbz  = fifo_rd[WIDTH];
`else
    logic unused_b_zero;
    assign unused_b_zero = in_b_zero;

    div_collect_fifo #(
        .DW    (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (exit_tag),
        .wr_data  (div_z),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .count    (count)
    );

    assign out_dbz = 1'b0;
`endif

endmodule

// File: tb/tb_div_collect.sv
// Bench for div_collect: plays the divider and compares against a queue-based model.
import div_pkg::*;

module tb_div_collect;

    localparam int W  = DIV_WIDTH;
    localparam int L  = DIV_LATENCY;
    localparam int D  = DIV_COLLECT_DEPTH;
    localparam int CW = $clog2(D) + 1;

    typedef struct {
        int         due;
        logic [W:0] item;
    } pend_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_b_zero;
    logic          in_ready;
    logic [W-1:0]  div_z;
    logic [W-1:0]  out_data;
    logic          out_dbz;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;

    pend_t       pend[$];
    logic [W:0]  fifo_q[$];
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned seq    = 1;

    div_collect #(
        .WIDTH   (W),
        .LATENCY (L),
        .DEPTH   (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_b_zero (in_b_zero),
        .in_ready  (in_ready),
        .div_z     (div_z),
        .out_data  (out_data),
        .out_dbz   (out_dbz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        logic [W:0] head;
        logic       exp_dbz;
        head = (fifo_q.size() != 0) ? fifo_q[0] : '0;
`ifdef DIV_COLLECT_ZERO_FLAG_EN
        exp_dbz = head[W];
`else
        exp_dbz = 1'b0;
`endif
        check_val("out_valid", 64'(out_valid), 64'(fifo_q.size() != 0));
        check_val("count", 64'(count), 64'(fifo_q.size()));
        check_val("out_data", 64'(out_data), 64'(head[W-1:0]));
        check_val("out_dbz", 64'(out_dbz), 64'(exp_dbz));
        check_val("in_ready", 64'(in_ready), 64'((fifo_q.size() + pend.size()) < D));
    endtask

    // One clock: the model decides issue/pop from its own state, the divider answer is
    // driven exactly on the landing edge, garbage otherwise.
    task automatic apply_stimulus(input logic v, input logic bz, input logic ordy,
                                  input logic [W-1:0] data, output logic issued);
        logic       do_pop;
        pend_t      p;
        logic [W:0] dropped;
        rst       = 1'b0;
        in_valid  = v;
        in_b_zero = bz;
        out_ready = ordy;
        issued = v && ((fifo_q.size() + pend.size()) < D);
        do_pop = ordy && (fifo_q.size() != 0);
        if (pend.size() != 0 && pend[0].due == edge_n + 1) div_z = pend[0].item[W-1:0];
        else div_z = $urandom;
        @(posedge clk);
        edge_n++;
        if (do_pop) dropped = fifo_q.pop_front();
        if (pend.size() != 0 && pend[0].due == edge_n) begin
            p = pend.pop_front();
            fifo_q.push_back(p.item);
        end
        if (issued) begin
            p.due  = edge_n + L;
            p.item = {bz, data};
            pend.push_back(p);
        end
        #1;
        check_output();
    endtask

    task automatic step(input logic v, input logic bz, input logic ordy, input logic [W-1:0] data);
        logic issued;
        apply_stimulus(v, bz, ordy, data, issued);
    endtask

    task automatic seq_step(input logic v, input logic bz, input logic ordy);
        logic issued;
        apply_stimulus(v, bz, ordy, W'(seq), issued);
        if (issued) seq++;
    endtask

    // Reset with in_valid held high: nothing may issue and everything in flight is lost.
    task automatic apply_reset(input int edges);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_b_zero = 1'b1;
        out_ready = 1'b1;
        repeat (edges) begin
            div_z = $urandom;
            @(posedge clk);
            edge_n++;
        end
        pend.delete();
        fifo_q.delete();
        #1;
        check_output();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] start W=%0d L=%0d D=%0d", W, L, D);
        apply_reset(2);
        repeat (L + 2) step(1'b0, 1'b0, 1'b0, '0);

        // single issue of 7, lands L edges later
        step(1'b1, 1'b0, 1'b0, 32'd7);
        repeat (L) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, '0);

        // gapped issues at relative edges 0,3,4
        step(1'b1, 1'b0, 1'b0, 32'd10);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 32'd20);
        step(1'b1, 1'b0, 1'b0, 32'd30);
        repeat (L + 1) step(1'b0, 1'b0, 1'b0, '0);
        repeat (4) step(1'b0, 1'b0, 1'b1, '0);

        // fill with no consumer: exactly D issues
        repeat (D + 8) seq_step(1'b1, 1'b0, 1'b0);
        repeat (L) seq_step(1'b1, 1'b0, 1'b0);

        // single pop from full, then the freed credit is reissued
        seq_step(1'b1, 1'b0, 1'b1);
        seq_step(1'b1, 1'b0, 1'b0);
        seq_step(1'b1, 1'b0, 1'b0);
        repeat (40) seq_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)));
        repeat (L + D + 2) seq_step(1'b0, 1'b0, 1'b1);

        // reset with five results in flight
        repeat (5) seq_step(1'b1, 1'b0, 1'b0);
        repeat (4) seq_step(1'b0, 1'b0, 1'b0);
        apply_reset(1);
        repeat (L + 4) seq_step(1'b0, 1'b0, 1'b1);

        // random soak
        repeat (300) seq_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 2) == 0));
        repeat (L + D + 2) seq_step(1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
